// File: rtl/hazard_sequencer_pkg.sv
// Shared opcode constants, FSM state encoding and control payload for the hazard sequencer.
package hazard_sequencer_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned REG_W = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned SC_W  = 16;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_CMP = 4'd8;
    localparam logic [OP_W-1:0] OP_LD  = 4'd12;
    localparam logic [OP_W-1:0] OP_ST  = 4'd13;
    localparam logic [OP_W-1:0] OP_BT  = 4'd14;
    localparam logic [OP_W-1:0] OP_NOP = 4'd15;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    // Pipeline control bundle produced each cycle by the sequencer
    typedef struct packed {
        logic mem_req;
        logic stall_f;
        logic stall_x;
        logic bubble_x;
        logic bubble_m;
        logic flush;
    } ctl_t;

    // True for opcodes that talk to data memory
    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/hazard_sequencer_load_use_detect.sv
// Flags an ID-stage read of the register an EX-stage load is about to write.
module load_use_detect
    import hazard_sequencer_pkg::*;
(
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_re_a,
    input  logic             id_re_b,
    input  logic [OP_W-1:0]  ex_opcode,
    input  logic [REG_W-1:0] ex_rd,
    output logic             hit_c
);

    // Only an actual read of a matching source counts; disabled ports are ignored
    always_comb begin
        hit_c = (ex_opcode == OP_LD) &&
                ((id_re_a && (id_ra == ex_rd)) || (id_re_b && (id_rb == ex_rd)));
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: branch flush, memory wait, multi-cycle MUL and load-use stalls.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_re_a,
    input  logic             id_re_b,
    input  logic [OP_W-1:0]  ex_opcode,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             stall_f,
    output logic             stall_x,
    output logic             bubble_x,
    output logic             bubble_m,
    output logic             flush,
    output logic             busy,
    output logic [SC_W-1:0]  stall_cycles
);

    // First MUL cycle is stalled from RUN, so the wait counter covers the remaining MUL_LAT-2
    localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
    localparam bit               MUL_STALLS = (MUL_LAT > 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SC_W-1:0]  sc_q;
    ctl_t             ctl;
    logic             lu_hit;

    load_use_detect u_load_use_detect (
        .id_ra     (id_ra),
        .id_rb     (id_rb),
        .id_re_a   (id_re_a),
        .id_re_b   (id_re_b),
        .ex_opcode (ex_opcode),
        .ex_rd     (ex_rd),
        .hit_c     (lu_hit)
    );

    // State and MUL wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and pipeline controls; priority in RUN is branch, memory, MUL, load-use
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl     = '0;
        unique case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    ctl.flush = 1'b1;
                    state_d   = ST_FLUSH;
                end else if (is_mem(ex_opcode)) begin
                    ctl.mem_req = 1'b1;
                    if (!mem_ack) begin
                        ctl.stall_f  = 1'b1;
                        ctl.stall_x  = 1'b1;
                        ctl.bubble_m = 1'b1;
                        state_d      = ST_MEM_WAIT;
                    end else if (lu_hit) begin
                        ctl.stall_f  = 1'b1;
                        ctl.bubble_x = 1'b1;
                    end
                end else if ((ex_opcode == OP_MUL) && MUL_STALLS) begin
                    ctl.stall_f  = 1'b1;
                    ctl.stall_x  = 1'b1;
                    ctl.bubble_m = 1'b1;
                    cnt_d        = MUL_RELOAD;
                    state_d      = ST_MUL_WAIT;
                end else if (lu_hit) begin
                    ctl.stall_f  = 1'b1;
                    ctl.bubble_x = 1'b1;
                end
            end
            ST_MUL_WAIT: begin
                if (cnt_q != '0) begin
                    ctl.stall_f  = 1'b1;
                    ctl.stall_x  = 1'b1;
                    ctl.bubble_m = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                ctl.mem_req = 1'b1;
                if (!mem_ack) begin
                    ctl.stall_f  = 1'b1;
                    ctl.stall_x  = 1'b1;
                    ctl.bubble_m = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    // The load leaves EX this cycle, so a dependent ID read must still wait one cycle
                    if (lu_hit) begin
                        ctl.stall_f  = 1'b1;
                        ctl.bubble_x = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                ctl.flush = 1'b1;
                state_d   = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating count of front-end stall cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q <= '0;
        end else if (ctl.stall_f && (sc_q != '1)) begin
            sc_q <= sc_q + SC_W'(1);
        end
    end

    assign mem_req      = ctl.mem_req;
    assign stall_f      = ctl.stall_f;
    assign stall_x      = ctl.stall_x;
    assign bubble_x     = ctl.bubble_x;
    assign bubble_m     = ctl.bubble_m;
    assign flush        = ctl.flush;
    assign busy         = (state_q != ST_RUN);
    assign stall_cycles = sc_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed scoreboard bench for hazard_sequencer (MUL_LAT = 3).
module tb_hazard_sequencer;

    // Control vector order: mem_req, stall_f, stall_x, bubble_x, bubble_m, flush, busy
    localparam logic [6:0] E_IDLE  = 7'b0000000;
    localparam logic [6:0] E_MUL1  = 7'b0110100;
    localparam logic [6:0] E_MUL2  = 7'b0110101;
    localparam logic [6:0] E_MULX  = 7'b0000001;
    localparam logic [6:0] E_MEM1  = 7'b1110100;
    localparam logic [6:0] E_MEMW  = 7'b1110101;
    localparam logic [6:0] E_MEMX  = 7'b1000001;
    localparam logic [6:0] E_MEMXL = 7'b1101001;
    localparam logic [6:0] E_LU    = 7'b1101000;
    localparam logic [6:0] E_MEMOK = 7'b1000000;
    localparam logic [6:0] E_FL1   = 7'b0000010;
    localparam logic [6:0] E_FL2   = 7'b0000011;

    localparam logic [3:0] NOP = 4'd15;
    localparam logic [3:0] MUL = 4'd2;
    localparam logic [3:0] LD  = 4'd12;
    localparam logic [3:0] ST  = 4'd13;
    localparam logic [3:0] ADD = 4'd0;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [15:0] sc;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  id_ra, id_rb, ex_opcode, ex_rd;
    logic        id_re_a, id_re_b, branch_taken, mem_ack;
    logic        mem_req, stall_f, stall_x, bubble_x, bubble_m, flush, busy;
    logic [15:0] stall_cycles;

    obs_t        sb_q[$];
    logic [15:0] exp_sc;
    int          checks;
    int          errors;

    hazard_sequencer #(.MUL_LAT(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_ra        (id_ra),
        .id_rb        (id_rb),
        .id_re_a      (id_re_a),
        .id_re_b      (id_re_b),
        .ex_opcode    (ex_opcode),
        .ex_rd        (ex_rd),
        .branch_taken (branch_taken),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .stall_f      (stall_f),
        .stall_x      (stall_x),
        .bubble_x     (bubble_x),
        .bubble_m     (bubble_m),
        .flush        (flush),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input int n);
        int s;
        s = int'(a) + n;
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    // Drive one cycle of inputs at the negedge, queue the expectation, compare mid-phase
    task automatic step(input string tag, input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] ra, input logic rea, input logic [3:0] rb,
                        input logic reb, input logic bt, input logic ack,
                        input logic [6:0] exp_ctl);
        obs_t exp_o, got_o;
        ex_opcode    = op;
        ex_rd        = rd;
        id_ra        = ra;
        id_re_a      = rea;
        id_rb        = rb;
        id_re_b      = reb;
        branch_taken = bt;
        mem_ack      = ack;
        exp_o.ctl = exp_ctl;
        exp_o.sc  = exp_sc;
        sb_q.push_back(exp_o);
        #2;
        got_o = {mem_req, stall_f, stall_x, bubble_x, bubble_m, flush, busy, stall_cycles};
        exp_o = sb_q.pop_front();
        checks++;
        assert (got_o === exp_o) else begin
            errors++;
            $error("FAIL %s got ctl=%b sc=%h exp ctl=%b sc=%h",
                   tag, got_o.ctl, got_o.sc, exp_o.ctl, exp_o.sc);
        end
        if (exp_ctl[5] && rst_n) exp_sc = sat_add(exp_sc, 1);
        @(negedge clk);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        exp_sc       = 16'h0000;
        rst_n        = 1'b0;
        ex_opcode    = NOP;
        ex_rd        = 4'd0;
        id_ra        = 4'd0;
        id_rb        = 4'd0;
        id_re_a      = 1'b0;
        id_re_b      = 1'b0;
        branch_taken = 1'b0;
        mem_ack      = 1'b0;
        @(negedge clk);

        step("reset", NOP, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
        rst_n = 1'b1;
        step("idle", NOP, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
        step("add", ADD, 3, 3, 1, 3, 1, 0, 0, E_IDLE);

        // MUL with latency 3: two stall cycles, released on the third
        step("mul_c1", MUL, 1, 0, 0, 0, 0, 0, 0, E_MUL1);
        step("mul_c2", MUL, 1, 0, 0, 0, 0, 0, 0, E_MUL2);
        step("mul_c3", MUL, 1, 0, 0, 0, 0, 1, 0, E_MULX);
        step("mul_after", NOP, 0, 0, 0, 0, 0, 0, 0, E_IDLE);

        // LD waiting three cycles for memory
        step("ld_w1", LD, 3, 0, 0, 0, 0, 0, 0, E_MEM1);
        step("ld_w2", LD, 3, 0, 0, 0, 0, 0, 0, E_MEMW);
        step("ld_w3", LD, 3, 0, 0, 0, 0, 0, 0, E_MEMW);
        step("ld_ack", LD, 3, 0, 0, 0, 0, 0, 1, E_MEMX);
        step("ld_after", NOP, 0, 0, 0, 0, 0, 0, 0, E_IDLE);

        // Load-use hazards on an immediately acked load
        step("lu_ra", LD, 5, 5, 1, 0, 0, 0, 1, E_LU);
        step("lu_ra_off", LD, 5, 5, 0, 0, 0, 0, 1, E_MEMOK);
        step("lu_rb", LD, 5, 0, 0, 5, 1, 0, 1, E_LU);
        step("lu_rb_off", LD, 5, 0, 0, 5, 0, 0, 1, E_MEMOK);
        step("lu_mismatch", LD, 5, 4, 1, 6, 1, 0, 1, E_MEMOK);
        step("st_no_lu", ST, 5, 5, 1, 5, 1, 0, 1, E_MEMOK);

        // Load-use rechecked when a stalled load finally completes
        step("ldlu_wait", LD, 7, 7, 1, 0, 0, 0, 0, E_MEM1);
        step("ldlu_exit", LD, 7, 7, 1, 0, 0, 0, 1, E_MEMXL);
        step("ldlu_after", NOP, 0, 7, 1, 0, 0, 0, 0, E_IDLE);

        // Taken branch over a ST: two flush cycles, no memory request
        step("bt_st_c1", ST, 2, 0, 0, 0, 0, 1, 0, E_FL1);
        step("bt_st_c2", ST, 2, 0, 0, 0, 0, 1, 0, E_FL2);
        step("bt_after", NOP, 0, 0, 0, 0, 0, 0, 0, E_IDLE);

        // Taken branch beats a MUL
        step("bt_mul_c1", MUL, 1, 0, 0, 0, 0, 1, 0, E_FL1);
        step("bt_mul_c2", MUL, 1, 0, 0, 0, 0, 0, 0, E_FL2);
        step("bt_mul_after", NOP, 0, 0, 0, 0, 0, 0, 0, E_IDLE);

        // Reset in the middle of a MUL wait
        step("rmul_c1", MUL, 1, 0, 0, 0, 0, 0, 0, E_MUL1);
        step("rmul_c2", MUL, 1, 0, 0, 0, 0, 0, 0, E_MUL2);
        rst_n  = 1'b0;
        exp_sc = 16'h0000;
        step("rst_mid_mul", NOP, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
        rst_n = 1'b1;
        step("post_rst", NOP, 0, 0, 0, 0, 0, 0, 0, E_IDLE);

        // Long memory stall drives the counter into saturation
        step("sat_w1", LD, 3, 0, 0, 0, 0, 0, 0, E_MEM1);
        step("sat_w2", LD, 3, 0, 0, 0, 0, 0, 0, E_MEMW);
        repeat (65532) @(negedge clk);
        exp_sc = sat_add(exp_sc, 65532);
        step("sat_fffe", LD, 3, 0, 0, 0, 0, 0, 0, E_MEMW);
        repeat (299) @(negedge clk);
        exp_sc = sat_add(exp_sc, 299);
        step("sat_ffff", LD, 3, 0, 0, 0, 0, 0, 0, E_MEMW);
        step("sat_ack", LD, 3, 0, 0, 0, 0, 0, 1, E_MEMX);
        step("sat_hold", NOP, 0, 0, 0, 0, 0, 0, 0, E_IDLE);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain got %0d entries exp 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter MUL_LAT, default 3: EX-stage cycles one MUL (opcode 2) occupies; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_ra, id_rb  input  4 each  source register indices of the ID-stage instruction.
REQ-005 id_re_a, id_re_b  input  1 each  read enables of the ID-stage instruction (RE_A/RE_B from the decoder).
REQ-006 ex_opcode  input  4  opcode of the EX-stage instruction.
REQ-007 ex_rd  input  4  destination register of the EX-stage instruction.
REQ-008 branch_taken  input  1  EX-stage BT resolved taken.
REQ-009 mem_ack  input  1  data memory accepted the current LD/ST request.
REQ-010 mem_req  output  1  request to data memory for the EX-stage LD/ST.
REQ-011 stall_f  output  1  hold PC and IF/ID.
REQ-012 stall_x  output  1  hold ID/EX (EX-stage instruction).
REQ-013 bubble_x  output  1  load NOP (4'hF) into ID/EX.
REQ-014 bubble_m  output  1  load NOP into EX/MEM.
REQ-015 flush  output  1  load NOP into IF/ID and ID/EX; select branch target for PC.
REQ-016 busy  output  1  state != RUN.
REQ-017 stall_cycles  output  16  count of cycles with stall_f=1, saturating at 16'hFFFF.

Function
REQ-018 FSM states RUN, MUL_WAIT, MEM_WAIT, FLUSH; 3-bit down-counter cnt.
REQ-019 RUN priority, highest first: branch_taken, LD/ST, MUL, load-use, none.
REQ-020 RUN with branch_taken=1: flush=1 this cycle, next state FLUSH; all other events ignored.
REQ-021 FLUSH: flush=1 for exactly one cycle, branch_taken ignored, next state RUN.
REQ-022 RUN with ex_opcode 12/13: mem_req=1; mem_ack=1 same cycle -> no stall, stay RUN; else stall_f=stall_x=bubble_m=1, next MEM_WAIT.
REQ-023 MEM_WAIT: mem_req=1; mem_ack=0 -> stall_f=stall_x=bubble_m=1, stay; mem_ack=1 -> all stalls 0, next RUN.
REQ-024 RUN with ex_opcode 2 and MUL_LAT>1: stall_f=stall_x=bubble_m=1, cnt<=MUL_LAT-2, next MUL_WAIT; MUL_LAT=1 -> no stall.
REQ-025 MUL_WAIT: cnt!=0 -> stall_f=stall_x=bubble_m=1, cnt decrements; cnt==0 -> stalls 0, next RUN; total stall = MUL_LAT-1 cycles.
REQ-026 Load-use, in RUN when ex_opcode=12 and (id_re_a and id_ra==ex_rd, or id_re_b and id_rb==ex_rd): stall_f=1, bubble_x=1, stall_x=0.
REQ-027 LD with mem_ack=0 takes the REQ-022 path; load-use is evaluated again in the MEM_WAIT exit cycle and asserts stall_f/bubble_x there if matched.
REQ-028 Outputs not asserted by a rule are 0; outputs combinational from state, cnt and inputs; stall_cycles registered.

Reset
REQ-029 rst_n low: state RUN, cnt 0, stall_cycles 0, regardless of in-flight MUL or memory wait.
REQ-030 During reset all outputs read 0 except those driven combinationally by inputs in RUN.

Structure
REQ-031 Shared package holds opcode constants (ADD 0, MUL 2, CMP 8, LD 12, ST 13, BT 14, NOP 15) and the state encoding.
REQ-032 Load-use comparison is sub-module load_use_detect (combinational, 4-bit compares).

Verification
REQ-033 MUL_LAT=3, ex_opcode=2 in RUN -> stall_f/stall_x/bubble_m high 2 cycles, low on 3rd; stall_cycles +2.
REQ-034 LD in EX, mem_ack low 3 cycles then high -> mem_req high 4 cycles, stalls high 3, busy high 3.
REQ-035 LD ex_rd=5, mem_ack=1, id_ra=5, id_re_a=1 -> stall_f=1, bubble_x=1, stall_x=0 one cycle; id_re_a=0 -> no stall.
REQ-036 branch_taken with ex_opcode=13 -> flush 2 cycles, mem_req 0.
REQ-037 rst_n low mid MUL_WAIT -> state RUN, stall_cycles 0; 300 stall cycles at 16'hFFFE -> stalls at 16'hFFFF.
